gcode_cmd_sequencer: RTL and testbench
======================================

Name: gcode_cmd_sequencer

Overview:
- Fetches a stored G-code program, one 32-bit command word per address, from a synchronous-read command RAM.
- Presents each command to the controller interface with a valid/ready handshake: cmd_valid drives the interface's memory_ready input, and controller_ready comes back from the motion controller.
- Stops on M2 (program end), on reaching prog_len, on an illegal opcode, or on an external block/abort.
- Sits between the command RAM (loaded by the host) and the controller interface.

Parameters:
ADDR_W, 8, command RAM address width; maximum program length is 2**ADDR_W words

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  single-cycle pulse; begins execution at address 0
block  in  1  abort request; level-sensitive; same net that feeds the controller interface
prog_len  in  ADDR_W+1  number of valid words in the RAM; sampled on start
mem_rd_en  out  1  RAM read strobe
mem_addr  out  ADDR_W  RAM read address
mem_rdata  in  32  RAM data, valid the cycle after mem_rd_en
controller_ready  in  1  controller accepts the presented command
cmd_valid  out  1  command presented; connects to the interface's memory_ready
cmd  out  4  opcode, mem_rdata[31:28]
x_value  out  14  mem_rdata[27:14]
y_value  out  14  mem_rdata[13:0]
pc  out  ADDR_W+1  index of the current/next command
busy  out  1  FSM is in FETCH, WAIT_DATA or PRESENT
done  out  1  program completed normally (level)
error  out  1  illegal opcode encountered (level)

Behaviour:
- Reset (async): all outputs 0; FSM to IDLE; latched prog_len = 0.
- Opcode encoding (fixed): G00=0, G01=1, G20=2, G21=3, G90=4, G91=5, M2=6, M6=7, M72=8. Codes 9–15 are illegal.
- FSM states: IDLE, FETCH, WAIT_DATA, PRESENT, DONE, ERROR.
- IDLE/DONE/ERROR, on start with block low:
  - Latch prog_len; pc <= 0; clear done and error.
  - If prog_len == 0, go to DONE; otherwise go to FETCH.
  - start is ignored in any other state.
- FETCH:
  - mem_rd_en = 1 and mem_addr = pc[ADDR_W-1:0], for exactly one cycle.
  - Next state is WAIT_DATA.
- WAIT_DATA:
  - Register cmd, x_value and y_value from mem_rdata.
  - Illegal opcode: go to ERROR (error = 1); pc is not advanced.
  - M2: go to DONE (done = 1); M2 is never presented.
  - Any other opcode: go to PRESENT.
- PRESENT:
  - cmd_valid = 1; cmd, x_value and y_value are held stable.
  - Transfer occurs on a cycle where cmd_valid & controller_ready & ~block. On transfer:
    - pc <= pc + 1.
    - If pc + 1 == latched prog_len, go to DONE; otherwise go to FETCH.
  - cmd_valid deasserts the cycle after the transfer.
- Latency:
  - start to first cmd_valid: 3 cycles.
  - Minimum 3 cycles per command (FETCH, WAIT_DATA, PRESENT), with controller_ready held high.
- block:
  - High in any state: go to IDLE next cycle and deassert cmd_valid.
  - block high on the same cycle as controller_ready counts as no transfer; pc is not advanced.
  - done and error are cleared.
  - start is ignored while block is high.
- Other boundaries:
  - pc is ADDR_W+1 bits, so pc == 2**ADDR_W is representable when prog_len is at its maximum; no wrap.
  - prog_len changes after start have no effect.
  - cmd, x_value and y_value retain their last values in IDLE, DONE and ERROR.

Decomposition:
- Shared package scara_pkg holds:
  - cmd_code_t, a 4-bit enum with the encoding above, also used by the controller interface.
  - Field-position constants CMD_MSB/LSB, X_MSB/LSB, Y_MSB/LSB.
  - Function is_legal_cmd().
- Single module; no sub-module. Decode is a package function, not a separate block.

Test Plan:
- Program {G01 x=100 y=200, G00 x=5 y=7}, prog_len=2, controller_ready=1 → cmd_valid first at start+3 with cmd=1, x=100, y=200. Second command presented 3 cycles later. done=1 and pc=2 after the second transfer.
- Same program with controller_ready low for 10 cycles → cmd_valid held for those 10 cycles with cmd, x and y stable; pc stays 0; transfer happens when ready rises.
- Program {G90, M2, G01} with prog_len=3 → only G90 is presented; done=1, pc=1; G01 is never fetched (mem_addr never 2).
- Word with opcode 12 at address 1 → error=1, pc=1, cmd_valid never asserted for that word; a following start clears error and restarts at address 0.
- block asserted together with controller_ready during PRESENT of command 0 → no transfer, pc=0, FSM goes to IDLE, cmd_valid=0 next cycle. start while block is high is ignored.
- reset asserted mid-PRESENT (asynchronously, between clock edges) → cmd_valid, busy and pc go to 0 immediately; start with prog_len=0 → done=1 one cycle later, no RAM read.

Source files
------------

// File: rtl/scara_pkg.sv
// Shared definitions for the SCARA G-code path: command opcode encoding,
// command-word field positions, sequencer state encoding and opcode legality.
package scara_pkg;

  typedef enum logic [3:0] {
    CMD_G00 = 4'd0,
    CMD_G01 = 4'd1,
    CMD_G20 = 4'd2,
    CMD_G21 = 4'd3,
    CMD_G90 = 4'd4,
    CMD_G91 = 4'd5,
    CMD_M2  = 4'd6,
    CMD_M6  = 4'd7,
    CMD_M72 = 4'd8
  } cmd_code_t;

  localparam int CMD_MSB = 31;
  localparam int CMD_LSB = 28;
  localparam int X_MSB   = 27;
  localparam int X_LSB   = 14;
  localparam int Y_MSB   = 13;
  localparam int Y_LSB   = 0;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_WAIT_DATA = 3'd2,
    ST_PRESENT   = 3'd3,
    ST_DONE      = 3'd4,
    ST_ERROR     = 3'd5
  } seq_state_t;

  // Codes above M72 are unassigned and must stop the program.
  function automatic logic is_legal_cmd(input logic [3:0] code);
    return (code <= 4'd8);
  endfunction

endpackage

// File: rtl/gcode_cmd_sequencer.sv
// G-code command sequencer: walks the command RAM from address 0, presents
// each legal command to the controller with a valid/ready handshake and
// stops on M2, on reaching the latched program length, on an illegal opcode
// or on block. All outputs are registered from the next-state decode.
module gcode_cmd_sequencer
  import scara_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              block,
  input  logic [ADDR_W:0]   prog_len,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  input  logic              controller_ready,
  output logic              cmd_valid,
  output logic [3:0]        cmd,
  output logic [13:0]       x_value,
  output logic [13:0]       y_value,
  output logic [ADDR_W:0]   pc,
  output logic              busy,
  output logic              done,
  output logic              error
);

  seq_state_t          r_state;
  seq_state_t          w_state_nxt;
  logic [ADDR_W:0]     r_pc;
  logic [ADDR_W:0]     w_pc_nxt;
  logic [ADDR_W:0]     w_pc_inc;
  logic [ADDR_W:0]     r_len;
  logic [ADDR_W:0]     w_len_nxt;
  logic                w_load_fields;
  logic [3:0]          w_op;
  logic [3:0]          r_cmd;
  logic [13:0]         r_x;
  logic [13:0]         r_y;
  logic                r_mem_rd_en;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic                r_cmd_valid;
  logic                r_busy;
  logic                r_done;
  logic                r_error;

  assign w_op     = mem_rdata[CMD_MSB:CMD_LSB];
  assign w_pc_inc = r_pc + {{ADDR_W{1'b0}}, 1'b1};

  // Next-state, program counter and length-latch decisions.
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_len_nxt     = r_len;
    w_load_fields = 1'b0;
    if (block) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            w_len_nxt   = prog_len;
            w_pc_nxt    = '0;
            w_state_nxt = (prog_len == '0) ? ST_DONE : ST_FETCH;
          end else begin
            w_state_nxt = r_state;
          end
        end
        ST_FETCH: begin
          w_state_nxt = ST_WAIT_DATA;
        end
        ST_WAIT_DATA: begin
          w_load_fields = 1'b1;
          if (!is_legal_cmd(w_op)) begin
            w_state_nxt = ST_ERROR;
          end else if (w_op == CMD_M2) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          if (controller_ready) begin
            w_pc_nxt    = w_pc_inc;
            w_state_nxt = (w_pc_inc == r_len) ? ST_DONE : ST_FETCH;
          end else begin
            w_state_nxt = ST_PRESENT;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // State, counters, command fields and registered output decode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_pc        <= '0;
      r_len       <= '0;
      r_cmd       <= 4'd0;
      r_x         <= 14'd0;
      r_y         <= 14'd0;
      r_mem_rd_en <= 1'b0;
      r_mem_addr  <= '0;
      r_cmd_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_len   <= w_len_nxt;
      if (w_load_fields) begin
        r_cmd <= w_op;
        r_x   <= mem_rdata[X_MSB:X_LSB];
        r_y   <= mem_rdata[Y_MSB:Y_LSB];
      end
      if (w_state_nxt == ST_FETCH) begin
        r_mem_addr <= w_pc_nxt[ADDR_W-1:0];
      end
      r_mem_rd_en <= (w_state_nxt == ST_FETCH);
      r_cmd_valid <= (w_state_nxt == ST_PRESENT);
      r_busy      <= (w_state_nxt == ST_FETCH) || (w_state_nxt == ST_WAIT_DATA) ||
                     (w_state_nxt == ST_PRESENT);
      r_done      <= (w_state_nxt == ST_DONE);
      r_error     <= (w_state_nxt == ST_ERROR);
    end
  end

  assign mem_rd_en = r_mem_rd_en;
  assign mem_addr  = r_mem_addr;
  assign cmd_valid = r_cmd_valid;
  assign cmd       = r_cmd;
  assign x_value   = r_x;
  assign y_value   = r_y;
  assign pc        = r_pc;
  assign busy      = r_busy;
  assign done      = r_done;
  assign error     = r_error;

endmodule

// File: tb/tb_gcode_cmd_sequencer.sv
// Self-checking bench for gcode_cmd_sequencer: directed scenarios plus
// randomized programs compared against a program-level reference model.
module tb_gcode_cmd_sequencer;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              block;
  logic [ADDR_W:0]   prog_len;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata;
  logic              controller_ready;
  logic              cmd_valid;
  logic [3:0]        cmd;
  logic [13:0]       x_value;
  logic [13:0]       y_value;
  logic [ADDR_W:0]   pc;
  logic              busy;
  logic              done;
  logic              error;

  gcode_cmd_sequencer #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .block(block), .prog_len(prog_len),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .controller_ready(controller_ready), .cmd_valid(cmd_valid), .cmd(cmd),
    .x_value(x_value), .y_value(y_value), .pc(pc), .busy(busy), .done(done),
    .error(error)
  );

  always #5 clk = ~clk;

  // Command RAM model: synchronous read, data valid the cycle after the strobe.
  logic [31:0] ram [0:255];
  always @(posedge clk) if (mem_rd_en) mem_rdata <= ram[mem_addr];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int op, input int x, input int y);
    logic [3:0]  o;
    logic [13:0] xv;
    logic [13:0] yv;
    o  = 4'(op);
    xv = 14'(x);
    yv = 14'(y);
    return {o, xv, yv};
  endfunction

  // Reference model: commands presented in order, then how the run ends.
  logic [31:0] exp_q[$];
  bit          exp_done;
  bit          exp_err;
  int          exp_pc;
  int          exp_last;

  task automatic build_expect(input int len);
    int op;
    exp_q.delete();
    exp_done = 1'b1;
    exp_err  = 1'b0;
    exp_pc   = len;
    exp_last = len - 1;
    for (int i = 0; i < len; i++) begin
      op = int'(ram[i][31:28]);
      if (op > 8) begin
        exp_done = 1'b0; exp_err = 1'b1; exp_pc = i; exp_last = i;
        break;
      end
      if (op == 6) begin
        exp_pc = i; exp_last = i;
        break;
      end
      exp_q.push_back(ram[i]);
    end
  endtask

  task automatic run_prog(input string name, input int len, input int ready_pct, input int stall);
    int   n_xfer;
    int   stall_left;
    int   v0;
    bit   fin;
    bit   xfer;
    logic rdy;
    build_expect(len);
    n_xfer = 0; stall_left = stall; v0 = 0; fin = 1'b0;
    @(negedge clk);
    prog_len = (ADDR_W+1)'(len);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    prog_len = (ADDR_W+1)'($urandom);
    check_eq({name, "_start_err"}, error, 0);
    check_eq({name, "_start_done"}, done, (len == 0));
    check_eq({name, "_start_busy"}, busy, (len != 0));
    for (int cyc = 1; cyc <= 2000; cyc++) begin
      if (done || error) begin
        fin = 1'b1;
        break;
      end
      if (mem_rd_en) check_eq({name, "_rd_addr"}, mem_addr, n_xfer);
      rdy = ($urandom_range(99) < ready_pct);
      if (cmd_valid) begin
        if (n_xfer < exp_q.size()) begin
          check_eq({name, "_cmd"}, cmd, exp_q[n_xfer][31:28]);
          check_eq({name, "_x"}, x_value, exp_q[n_xfer][27:14]);
          check_eq({name, "_y"}, y_value, exp_q[n_xfer][13:0]);
        end else begin
          check_eq({name, "_extra_valid"}, 1, 0);
        end
        check_eq({name, "_pc_hold"}, pc, n_xfer);
        if (ready_pct == 100 && stall == 0) check_eq({name, "_valid_cycle"}, cyc, 3 + 3 * n_xfer);
        if (n_xfer == 0) begin
          v0++;
          if (stall_left > 0) begin
            rdy = 1'b0;
            stall_left--;
          end
        end
      end
      controller_ready = rdy;
      xfer = cmd_valid && rdy;
      @(negedge clk);
      if (xfer) n_xfer++;
    end
    controller_ready = 1'b0;
    check_eq({name, "_finished"}, fin, 1);
    check_eq({name, "_done"}, done, exp_done);
    check_eq({name, "_error"}, error, exp_err);
    check_eq({name, "_pc"}, pc, exp_pc);
    check_eq({name, "_xfers"}, n_xfer, exp_q.size());
    check_eq({name, "_busy_end"}, busy, 0);
    check_eq({name, "_valid_end"}, cmd_valid, 0);
    if (exp_last >= 0) check_eq({name, "_last_cmd"}, cmd, ram[exp_last][31:28]);
    if (ready_pct == 100 && exp_q.size() > 0) check_eq({name, "_first_hold"}, v0, stall + 1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; block = 1'b0; controller_ready = 1'b0; prog_len = '0;
    for (int i = 0; i < 256; i++) ram[i] = 32'd0;
    repeat (2) @(negedge clk);
    check_eq("rst_valid", cmd_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_pc", pc, 0);
    check_eq("rst_flags", {done, error, mem_rd_en}, 0);
    reset = 1'b0;

    // Two-command program, controller always ready, then with a 10-cycle stall.
    ram[0] = mk(1, 100, 200);
    ram[1] = mk(0, 5, 7);
    run_prog("two", 2, 100, 0);
    run_prog("stall", 2, 100, 10);

    // M2 ends the program before the length limit; G01 behind it is never read.
    ram[0] = mk(4, 0, 0);
    ram[1] = mk(6, 0, 0);
    ram[2] = mk(1, 9, 9);
    run_prog("m2", 3, 100, 0);

    // block clears done.
    block = 1'b1;
    @(negedge clk);
    check_eq("blk_clr_done", done, 0);
    block = 1'b0;

    // block together with ready during PRESENT of command 0.
    ram[0] = mk(1, 100, 200);
    ram[1] = mk(0, 5, 7);
    @(negedge clk);
    prog_len = 9'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("blk_pre_valid", cmd_valid, 1);
    controller_ready = 1'b1; block = 1'b1;
    @(negedge clk);
    check_eq("blk_valid", cmd_valid, 0);
    check_eq("blk_pc", pc, 0);
    check_eq("blk_busy", busy, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check_eq("blk_start_ignored", {busy, mem_rd_en}, 0);
    controller_ready = 1'b0; block = 1'b0;
    @(negedge clk);
    check_eq("blk_idle", busy, 0);

    // Illegal opcode at address 1, then a restart from address 0.
    ram[0] = mk(1, 1, 2);
    ram[1] = mk(12, 3, 4);
    run_prog("illegal", 3, 100, 0);
    run_prog("restart", 3, 60, 0);

    // Reset asserted between clock edges while presenting.
    ram[0] = mk(1, 100, 200);
    @(negedge clk);
    prog_len = 9'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("arst_pre_valid", cmd_valid, 1);
    #2 reset = 1'b1;
    #1;
    check_eq("arst_valid", cmd_valid, 0);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_pc", pc, 0);
    @(negedge clk);
    reset = 1'b0;
    prog_len = 9'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("len0_done", done, 1);
    check_eq("len0_rd", {mem_rd_en, busy}, 0);
    @(negedge clk);
    check_eq("len0_rd2", mem_rd_en, 0);

    // Full-size program: pc reaches 2**ADDR_W without wrapping.
    for (int i = 0; i < 256; i++) ram[i] = mk(1, $urandom, $urandom);
    run_prog("maxlen", 256, 100, 0);

    // Randomized programs with occasional M2 / illegal words and random readiness.
    for (int t = 0; t < 30; t++) begin
      int len;
      int r;
      len = $urandom_range(12, 0);
      for (int i = 0; i < 16; i++) begin
        r = $urandom_range(99);
        if (r < 7)       ram[i] = mk(6, $urandom, $urandom);
        else if (r < 15) ram[i] = mk($urandom_range(15, 9), $urandom, $urandom);
        else begin
          int op;
          op = $urandom_range(7);
          if (op >= 6) op = op + 1;
          ram[i] = mk(op, $urandom, $urandom);
        end
      end
      run_prog("rnd", len, $urandom_range(100, 30), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
